ctrl_decode_scoreboard: RTL and testbench
=========================================

Name: ctrl_decode_scoreboard

Overview:
- Pipelined successor to the combinational opcode-to-control decoder.
- Decodes the ID-stage instruction into a packed control word and registers it into the ID/EX pipeline register using a valid/ready handshake.
- Tracks outstanding multi-cycle writes to the integer and FP register files in a per-register countdown scoreboard, and stalls ID on RAW hazards that forwarding cannot cover.
- Sits between instruction fetch/decode and the EXE stage of the CPU.

Parameters:
- FP_LAT, 3, EXE-to-writeback latency of F-ALU ops (Fcal); range 1..7.
- LOAD_LAT, 1, extra cycles before a Load/Flw result can be forwarded; range 0..7.
- REG_AW, 5, register index width (32 int + 32 FP registers).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- id_valid  in  1  ID instruction valid
- id_ready  out  1  ID instruction accepted this cycle
- id_inst  in  32  raw instruction
- flush  in  1  kill the ID instruction and the ID/EX register contents (branch/jump redirect)
- ex_valid  out  1  ID/EX register holds a live instruction
- ex_ready  in  1  EXE consumes the ID/EX register this cycle
- ex_ctrl  out  22  packed ctrl_t: {immtype[2:0], aluop[2:0], regdst, alusrc, isjal[1:0], branch, memwrite[3:0] (active-low byte enables), memread, regwrite, memtoreg, float_rs1, float_rs2, float_rd}
- ex_rd / ex_rs1 / ex_rs2  out  REG_AW each  register indices of the held instruction
- ex_funct3  out  3  funct3 of the held instruction
- ex_illegal  out  1  held opcode is not in the supported set

Behaviour:
- Decode (combinational, internal) supports R, I, Load, Jalr, S, B, JAL, AUIPC, LUI, Flw, Fsw, Fcal and CSR.
  - Store byte enables by funct3: SW→0000, SB→1110, SH→1100, other→1111.
  - Unsupported opcode → NOP word (all zero except memwrite=1111) with illegal=1.
- Source usage:
  - rs1 is used by R, I, Load, Jalr, S, B, Flw, Fsw, Fcal and CSR.
  - rs2 is used by R, S, B, Fsw and Fcal.
  - Each source's register file is selected by float_rs1 / float_rs2.
- Scoreboard:
  - 64 counters (32 int, 32 FP), each $clog2(max(FP_LAT,LOAD_LAT)+1) bits. A counter is "busy" when nonzero.
  - Every cycle, each nonzero counter decrements by 1.
  - On issue of a regwrite instruction, the rd counter (in the file chosen by float_rd) loads:
    - FP_LAT for Fcal,
    - LOAD_LAT for Load/Flw,
    - 0 otherwise (full forwarding).
  - If the load and the decrement hit the same counter in the same cycle, the load wins.
  - Integer x0 is never marked busy; FP f0 is an ordinary register.
- hazard = id_valid && any used source is busy.
- id_ready = flush || (!hazard && (!ex_valid || ex_ready)).
- Issue = id_valid && id_ready && !flush. On issue, the next cycle has ex_valid=1 and the ex_* fields are loaded.
- If ex_ready && !issue, ex_valid clears next cycle. If neither ex_ready nor issue, ex_* hold unchanged (stall); outputs stay stable while ex_valid && !ex_ready.
- Flush:
  - ex_valid=0 next cycle and the ID instruction is dropped (id_ready=1).
  - If ex_valid && ex_ctrl.regwrite, the held instruction's rd counter is cleared to 0, overriding the decrement.
  - Counters of instructions already past EXE are unaffected.
- Latency: 1 cycle from issue to ex_valid. Stall cycles for a dependent op directly behind an Fcal = FP_LAT.
- Reset (async assert, sync-safe deassert):
  - ex_valid=0, ex_ctrl=NOP word, ex_rd/rs1/rs2/funct3=0, ex_illegal=0, all counters=0.
  - Reset asserted mid-stall discards all state.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams,
  - ALU-op localparams (R_ALU, I_ALU, ADD, SUB, LUI, U_ALU, F_ALU, CSR),
  - packed struct ctrl_t,
  - the NOP_CTRL constant.
- Sub-module ctrl_decode (pure combinational opcode/funct3 → ctrl_t + illegal + rs-use flags).
- The top level holds the scoreboard, handshake and ID/EX register.

Test Plan:
- Reset: rst_n=0 mid-stream → ex_valid=0, ex_ctrl=NOP (memwrite=1111), id_ready=1 after release with ex_valid=0.
- Back-to-back ALU: ADD x1,x2,x3 then ADD x4,x1,x1, ex_ready=1 → both issue in consecutive cycles, no stall, ex_rd=1 then 4.
- FP RAW with FP_LAT=3: FADD f1 then FADD f2,f1,f1 → id_ready=0 for exactly 3 cycles, second issues on cycle 4; no stall for FADD f2,f3,f4.
- Load-use with LOAD_LAT=1: LW x5 then ADD x6,x5,x0 → 1 stall cycle. Load to x0 → 0 stalls.
- Backpressure: ex_ready=0 for 4 cycles with ex_valid=1 → ex_ctrl/ex_rd stable, id_ready=0; SB decodes memwrite=1110.
- Flush: Fcal f7 held in ID/EX, flush=1 with dependent FADD f8,f7 at ID → ex_valid=0, f7 counter 0, next FADD f8,f7 issues without stall. Undefined opcode 7'h7F → ex_illegal=1, NOP word.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage decoder and the ID/EX scoreboard:
// opcodes, ALU-op codes, immediate formats and the packed control word.
package ctrl_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_FLW   = 7'b0000111;
    localparam logic [6:0] OP_FSW   = 7'b0100111;
    localparam logic [6:0] OP_FCAL  = 7'b1010011;
    localparam logic [6:0] OP_CSR   = 7'b1110011;

    localparam logic [2:0] R_ALU = 3'd0;
    localparam logic [2:0] I_ALU = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] SUB   = 3'd3;
    localparam logic [2:0] LUI   = 3'd4;
    localparam logic [2:0] U_ALU = 3'd5;
    localparam logic [2:0] F_ALU = 3'd6;
    localparam logic [2:0] CSR   = 3'd7;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // isjal: 01 = JAL, 10 = JALR; memwrite is active-low per byte lane
    typedef struct packed {
        logic [2:0] immtype;
        logic [2:0] aluop;
        logic       regdst;
        logic       alusrc;
        logic [1:0] isjal;
        logic       branch;
        logic [3:0] memwrite;
        logic       memread;
        logic       regwrite;
        logic       memtoreg;
        logic       float_rs1;
        logic       float_rs2;
        logic       float_rd;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '{
        immtype: IMM_NONE, aluop: R_ALU, regdst: 1'b0, alusrc: 1'b0,
        isjal: 2'b00, branch: 1'b0, memwrite: 4'b1111, memread: 1'b0,
        regwrite: 1'b0, memtoreg: 1'b0, float_rs1: 1'b0, float_rs2: 1'b0,
        float_rd: 1'b0
    };

    function automatic logic [3:0] store_be(input logic [2:0] funct3);
        case (funct3)
            3'b010:  store_be = 4'b0000;
            3'b000:  store_be = 4'b1110;
            3'b001:  store_be = 4'b1100;
            default: store_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct3 decoder: control word, illegal flag,
// source-use flags and the write-latency class of the instruction.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       use_rs1,
    output logic       use_rs2,
    output logic       is_fcal,
    output logic       is_load
);

    always_comb begin
        ctrl    = NOP_CTRL;
        illegal = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_fcal = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.aluop = R_ALU; ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_I: begin
                ctrl.immtype = IMM_I; ctrl.aluop = I_ALU; ctrl.alusrc = 1'b1;
                ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_LOAD, OP_FLW: begin
                ctrl.immtype = IMM_I; ctrl.aluop = ADD; ctrl.alusrc = 1'b1;
                ctrl.regdst = 1'b1; ctrl.memread = 1'b1; ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1; ctrl.float_rd = (opcode == OP_FLW);
                use_rs1 = 1'b1; is_load = 1'b1;
            end
            OP_JALR: begin
                ctrl.immtype = IMM_I; ctrl.aluop = ADD; ctrl.alusrc = 1'b1;
                ctrl.isjal = 2'b10; ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_S, OP_FSW: begin
                ctrl.immtype = IMM_S; ctrl.aluop = ADD; ctrl.alusrc = 1'b1;
                ctrl.memwrite = store_be(funct3);
                ctrl.float_rs2 = (opcode == OP_FSW);
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_B: begin
                ctrl.immtype = IMM_B; ctrl.aluop = SUB; ctrl.branch = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_JAL: begin
                ctrl.immtype = IMM_J; ctrl.aluop = ADD; ctrl.isjal = 2'b01;
                ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.immtype = IMM_U; ctrl.aluop = U_ALU; ctrl.alusrc = 1'b1;
                ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1;
            end
            OP_LUI: begin
                ctrl.immtype = IMM_U; ctrl.aluop = LUI; ctrl.alusrc = 1'b1;
                ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1;
            end
            OP_FCAL: begin
                ctrl.aluop = F_ALU; ctrl.regdst = 1'b1; ctrl.regwrite = 1'b1;
                ctrl.float_rs1 = 1'b1; ctrl.float_rs2 = 1'b1; ctrl.float_rd = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; is_fcal = 1'b1;
            end
            OP_CSR: begin
                ctrl.immtype = IMM_I; ctrl.aluop = CSR; ctrl.regdst = 1'b1;
                ctrl.regwrite = 1'b1;
                use_rs1 = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_decode_scoreboard.sv
// ID stage decode + ID/EX pipeline register with a per-register countdown
// scoreboard that stalls ID on RAW hazards forwarding cannot cover.
module ctrl_decode_scoreboard
    import ctrl_pkg::*;
#(
    parameter int FP_LAT   = 3,
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_inst,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [21:0]       ex_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [2:0]        ex_funct3,
    output logic              ex_illegal
);

    localparam int NREG    = 1 << REG_AW;
    localparam int MAX_LAT = (FP_LAT > LOAD_LAT) ? FP_LAT : LOAD_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    ctrl_t             dec_ctrl;
    logic              dec_illegal, use_rs1, use_rs2, is_fcal, is_load;
    logic [REG_AW-1:0] id_rd, id_rs1, id_rs2;
    logic [2:0]        id_funct3;
    logic              unused_inst_bits;

    assign id_rd            = id_inst[7 +: REG_AW];
    assign id_rs1           = id_inst[15 +: REG_AW];
    assign id_rs2           = id_inst[20 +: REG_AW];
    assign id_funct3        = id_inst[14:12];
    assign unused_inst_bits = ^id_inst[31:25];

    ctrl_decode u_decode (
        .opcode  (id_inst[6:0]),
        .funct3  (id_funct3),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .is_fcal (is_fcal),
        .is_load (is_load)
    );

    logic [CW-1:0] int_cnt [NREG];
    logic [CW-1:0] fp_cnt  [NREG];
    logic [NREG-1:0] int_busy, fp_busy;

    always_comb begin
        int_busy = '0;
        fp_busy  = '0;
        for (int i = 0; i < NREG; i++) begin
            int_busy[i] = (int_cnt[i] != '0);
            fp_busy[i]  = (fp_cnt[i] != '0);
        end
    end

    logic  busy1, busy2, hazard, issue;
    ctrl_t ex_ctrl_q;

    assign busy1  = dec_ctrl.float_rs1 ? fp_busy[id_rs1] : int_busy[id_rs1];
    assign busy2  = dec_ctrl.float_rs2 ? fp_busy[id_rs2] : int_busy[id_rs2];
    assign hazard = id_valid && ((use_rs1 && busy1) || (use_rs2 && busy2));

    // Handshake: a transfer happens on a cycle where valid && ready; ID/EX
    // contents stay stable while ex_valid && !ex_ready. Flush drops ID.
    assign id_ready = flush || (!hazard && (!ex_valid || ex_ready));
    assign issue    = id_valid && id_ready && !flush;

    logic [CW-1:0] wr_lat;
    logic          load_int, load_fp, clr_int, clr_fp;

    assign wr_lat   = is_fcal ? CW'(FP_LAT) : (is_load ? CW'(LOAD_LAT) : '0);
    assign load_int = issue && dec_ctrl.regwrite && !dec_ctrl.float_rd && (id_rd != '0);
    assign load_fp  = issue && dec_ctrl.regwrite && dec_ctrl.float_rd;
    assign clr_int  = flush && ex_valid && ex_ctrl_q.regwrite && !ex_ctrl_q.float_rd;
    assign clr_fp   = flush && ex_valid && ex_ctrl_q.regwrite && ex_ctrl_q.float_rd;

    // Priority per counter: issue load, then flush clear, then decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                int_cnt[i] <= '0;
                fp_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (load_int && id_rd == REG_AW'(i))
                    int_cnt[i] <= wr_lat;
                else if (clr_int && ex_rd == REG_AW'(i))
                    int_cnt[i] <= '0;
                else if (int_cnt[i] != '0)
                    int_cnt[i] <= int_cnt[i] - 1'b1;

                if (load_fp && id_rd == REG_AW'(i))
                    fp_cnt[i] <= wr_lat;
                else if (clr_fp && ex_rd == REG_AW'(i))
                    fp_cnt[i] <= '0;
                else if (fp_cnt[i] != '0)
                    fp_cnt[i] <= fp_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctrl_q  <= NOP_CTRL;
            ex_rd      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_funct3  <= '0;
            ex_illegal <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (issue) begin
            ex_valid   <= 1'b1;
            ex_ctrl_q  <= dec_ctrl;
            ex_rd      <= id_rd;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_funct3  <= id_funct3;
            ex_illegal <= dec_illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // The control word is 21 bits wide; bit 21 of the port is reserved as zero
    assign ex_ctrl = {1'b0, ex_ctrl_q};

endmodule

// File: tb/tb_ctrl_decode_scoreboard.sv
// Directed bench for ctrl_decode_scoreboard with FP_LAT=3, LOAD_LAT=1.
module tb_ctrl_decode_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready, flush, ex_valid, ex_ready, ex_illegal;
    logic [31:0] id_inst;
    logic [21:0] ex_ctrl;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [2:0]  ex_funct3;

    int n_checks = 0;
    int n_pass   = 0;
    int stalls;

    localparam logic [31:0] CTRL_NOP  = 32'h003C0;
    localparam logic [31:0] CTRL_ADD  = 32'h043D0;
    localparam logic [31:0] CTRL_FADD = 32'h343D7;
    localparam logic [31:0] CTRL_LW   = 32'h563F8;
    localparam logic [31:0] CTRL_SB   = 32'h92380;

    always #5 clk = ~clk;

    ctrl_decode_scoreboard #(.FP_LAT(3), .LOAD_LAT(1), .REG_AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_inst    (id_inst),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_ctrl    (ex_ctrl),
        .ex_rd      (ex_rd),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_funct3  (ex_funct3),
        .ex_illegal (ex_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sb(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, 5'b0, 7'b0100011};
    endfunction

    // Present inst at ID from a negedge, count cycles with id_ready=0, then let it issue
    task automatic issue(input logic [31:0] inst, output int n);
        id_valid = 1'b1;
        id_inst  = inst;
        n = 0;
        #1;
        while (!id_ready && n < 20) begin
            @(posedge clk); @(negedge clk); #1;
            n++;
        end
        @(posedge clk); @(negedge clk);
        id_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_inst = '0; flush = 1'b0; ex_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ex_valid", {31'b0, ex_valid}, 0);
        check("rst_ex_ctrl", {10'b0, ex_ctrl}, CTRL_NOP);
        check("rst_ex_rd", {27'b0, ex_rd}, 0);
        check("rst_ex_illegal", {31'b0, ex_illegal}, 0);
        rst_n = 1'b1;
        #1;
        check("rst_id_ready", {31'b0, id_ready}, 1);

        // back-to-back ALU with full forwarding
        issue(enc_r(7'b0110011, 5'd1, 5'd2, 5'd3), stalls);
        check("add1_stalls", stalls, 0);
        check("add1_valid", {31'b0, ex_valid}, 1);
        check("add1_rd", {27'b0, ex_rd}, 1);
        check("add1_ctrl", {10'b0, ex_ctrl}, CTRL_ADD);
        issue(enc_r(7'b0110011, 5'd4, 5'd1, 5'd1), stalls);
        check("add2_stalls", stalls, 0);
        check("add2_rd", {27'b0, ex_rd}, 4);
        check("add2_rs1", {27'b0, ex_rs1}, 1);

        // FP RAW: FP_LAT stall cycles, independent op none
        issue(enc_r(7'b1010011, 5'd1, 5'd2, 5'd3), stalls);
        check("fadd1_stalls", stalls, 0);
        issue(enc_r(7'b1010011, 5'd2, 5'd1, 5'd1), stalls);
        check("fadd_raw_stalls", stalls, 3);
        check("fadd_raw_rd", {27'b0, ex_rd}, 2);
        check("fadd_ctrl", {10'b0, ex_ctrl}, CTRL_FADD);
        issue(enc_r(7'b1010011, 5'd2, 5'd3, 5'd4), stalls);
        check("fadd_indep_stalls", stalls, 0);

        // load-use
        issue(enc_lw(5'd5, 5'd2), stalls);
        check("lw_stalls", stalls, 0);
        check("lw_ctrl", {10'b0, ex_ctrl}, CTRL_LW);
        check("lw_funct3", {29'b0, ex_funct3}, 2);
        issue(enc_r(7'b0110011, 5'd6, 5'd5, 5'd0), stalls);
        check("load_use_stalls", stalls, 1);
        issue(enc_lw(5'd0, 5'd2), stalls);
        issue(enc_r(7'b0110011, 5'd6, 5'd0, 5'd0), stalls);
        check("load_x0_stalls", stalls, 0);

        // backpressure holds SB in ID/EX
        issue(enc_sb(5'd2, 5'd3), stalls);
        check("sb_stalls", stalls, 0);
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_inst  = enc_r(7'b0110011, 5'd7, 5'd1, 5'd1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_id_ready", {31'b0, id_ready}, 0);
            check("bp_ex_valid", {31'b0, ex_valid}, 1);
            check("bp_sb_ctrl", {10'b0, ex_ctrl}, CTRL_SB);
            check("bp_ex_rd", {27'b0, ex_rd}, 0);
            @(posedge clk); @(negedge clk);
        end
        ex_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, id_ready}, 1);
        @(posedge clk); @(negedge clk);
        id_valid = 1'b0;
        check("bp_next_rd", {27'b0, ex_rd}, 7);

        // flush kills held Fcal and clears its counter
        issue(enc_r(7'b1010011, 5'd7, 5'd1, 5'd1), stalls);
        check("f7_stalls", stalls, 0);
        ex_ready = 1'b0;
        id_valid = 1'b1;
        id_inst  = enc_r(7'b1010011, 5'd8, 5'd7, 5'd7);
        flush    = 1'b1;
        #1;
        check("flush_id_ready", {31'b0, id_ready}, 1);
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        check("flush_ex_valid", {31'b0, ex_valid}, 0);
        ex_ready = 1'b1;
        issue(enc_r(7'b1010011, 5'd8, 5'd7, 5'd7), stalls);
        check("post_flush_stalls", stalls, 0);
        check("post_flush_rd", {27'b0, ex_rd}, 8);

        // undefined opcode
        issue(32'h0000007F, stalls);
        check("illegal_flag", {31'b0, ex_illegal}, 1);
        check("illegal_ctrl", {10'b0, ex_ctrl}, CTRL_NOP);

        // reset in the middle of a stall
        issue(enc_r(7'b1010011, 5'd9, 5'd1, 5'd1), stalls);
        id_valid = 1'b1;
        id_inst  = enc_r(7'b1010011, 5'd10, 5'd9, 5'd9);
        #1;
        check("pre_rst_stall", {31'b0, id_ready}, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ex_valid", {31'b0, ex_valid}, 0);
        check("mid_rst_ex_ctrl", {10'b0, ex_ctrl}, CTRL_NOP);
        check("mid_rst_ex_rd", {27'b0, ex_rd}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_id_ready", {31'b0, id_ready}, 1);
        id_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
